hack_fetch_ctrl: RTL and testbench
==================================

// Module: hack_fetch_ctrl
// PURPOSE
//  Fetch/execute sequencer for the Hack CPU program counter. Drives the PC's reset/load/inc controls.
//  Fetches each instruction from instruction ROM over a req/ack handshake and hands it to the datapath.
//  On datapath completion it resolves the jump field against the ALU flags zr/ng.
//  Sits between PC, ROM and the CPU datapath; one instruction in flight, PC never driven twice per instr.
// PARAMETERS
//  TIMEOUT   16  max cycles FETCH waits for rom_ack before flagging fetch_err (>=2)
//  CNT_W     16  width of retired-instruction counter
// PORTS
//  clk         in   1      single clock, all state updates on rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  pc_value    in   16     current PC register output
//  pc_reset    out  1      PC reset control (one-cycle pulse)
//  pc_load     out  1      PC load control (PC takes A-register value, muxed outside)
//  pc_inc      out  1      PC increment control
//  rom_req     out  1      instruction fetch request, held until ack
//  rom_addr    out  15     = pc_value[14:0] while rom_req
//  rom_ack     in   1      ROM data valid this cycle
//  rom_data    in   16     instruction word, sampled when rom_ack & rom_req
//  instr       out  16     latched instruction register
//  exec_valid  out  1      instr valid for datapath (high throughout EXEC)
//  exec_done   in   1      datapath finished; zr/ng valid this cycle
//  zr, ng      in   1 each ALU zero / negative flags
//  halt_req    in   1      stop at next instruction boundary
//  restart     in   1      synchronous soft restart to address 0
//  halted      out  1      high in HALT
//  fetch_err   out  1      sticky ROM timeout flag
//  retired     out  CNT_W  retired instruction count, wraps
// BEHAVIOUR
//  States: BOOT, FETCH, EXEC, HALT. reset_n low: state=BOOT, instr=0, retired=0, fetch_err=0, wait cnt=0.
//  Outputs are decodes of state (+inputs in EXEC); at most one of pc_reset/pc_load/pc_inc high per cycle.
//  BOOT: pc_reset=1 for exactly one cycle -> FETCH. First rom_addr after reset is 0.
//  FETCH: rom_req=1. rom_ack=1 -> instr<=rom_data, -> EXEC. Ack in any other state ignored.
//   Wait cnt counts no-ack cycles; TIMEOUT consecutive no-ack cycles -> fetch_err<=1, -> HALT.
//   Ack on the timeout cycle wins (normal capture, no error). Wait cnt clears on entering FETCH.
//  EXEC: exec_valid=1; hold until exec_done. On exec_done (same cycle, combinational):
//   instr[15]=0 (A-instr): pc_inc=1.
//   instr[15]=1: jump = (j[2]&ng)|(j[1]&zr)|(j[0]&~zr&~ng), j=instr[2:0]; jump ? pc_load=1 : pc_inc=1.
//   retired<=retired+1 (mod 2^CNT_W). Next: halt_req ? HALT : FETCH (PC already updated; no bubble).
//  HALT: halted=1, no PC controls. fetch_err=0 and halt_req=0 -> FETCH. fetch_err=1: exit only via restart.
//  restart (states FETCH/EXEC/HALT): highest priority -> BOOT next cycle; suppresses that cycle's
//   pc_load/pc_inc and retire; outstanding fetch abandoned (same-cycle rom_ack ignored);
//   clears fetch_err and retired. restart in BOOT ignored.
//  reset_n asserted mid-fetch/exec: immediate BOOT, all outputs to reset values, no PC pulse until release.
// TESTING
//  Release reset -> pc_reset pulse 1 cycle, then rom_req=1 rom_addr=0; retired=0, halted=0.
//  rom_data=0x0005, ack after 2 wait cycles, exec_done next -> instr=0x0005, pc_inc 1 cycle, retired=1.
//  0xEA87 (0;JMP) exec_done -> pc_load; 0xE301 (D;JGT): zr=1 -> pc_inc, zr=0 ng=0 -> pc_load; JLT ng=1 -> pc_load.
//  TIMEOUT=4, no ack -> fetch_err=1 and halted=1 after 4th idle cycle; halt_req toggle no exit; restart -> BOOT.
//  restart with exec_done same cycle -> no pc_inc/pc_load, retired cleared, pc_reset pulse next cycle.
//  halt_req held during EXEC -> PC updated on exec_done, HALT, halted=1; drop halt_req -> FETCH at new PC.

Source files
------------

// File: rtl/hack_fetch_ctrl_if.sv
// Instruction ROM fetch channel between the Hack fetch sequencer and the ROM.
// The sequencer holds rom_req until the ROM answers with rom_ack and rom_data.
interface hack_fetch_ctrl_if;
    logic        rom_req;
    logic [14:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_ack,
        input  rom_data
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_ack,
        output rom_data
    );
endinterface

// File: rtl/hack_fetch_ctrl.sv
// Fetch/execute sequencer for the Hack CPU. Pulses the PC controls, fetches one
// instruction at a time over the ROM channel, and resolves the jump field
// against the ALU flags when the datapath reports completion.
module hack_fetch_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [15:0]         pc_value,
    output logic                pc_reset,
    output logic                pc_load,
    output logic                pc_inc,
    hack_fetch_ctrl_if.master   rom,
    output logic [15:0]         instr,
    output logic                exec_valid,
    input  logic                exec_done,
    input  logic                zr,
    input  logic                ng,
    input  logic                halt_req,
    input  logic                restart,
    output logic                halted,
    output logic                fetch_err,
    output logic [CNT_W-1:0]    retired
);

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_armed;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [15:0]       r_instr;
    logic              r_fetch_err;
    logic [CNT_W-1:0]  r_retired;

    logic              w_pc_reset;
    logic              w_pc_load;
    logic              w_pc_inc;
    logic              w_rom_req;
    logic              w_exec_valid;
    logic              w_halted;
    logic              w_capture;
    logic              w_timeout;
    logic              w_retire;
    logic              w_restart;
    logic              w_jump;
    logic              w_unused_pc_msb;

    // PC bit 15 is outside the 32K-word ROM address space
    assign w_unused_pc_msb = pc_value[15];

    // Restart is honoured everywhere except BOOT, which is already restarting
    assign w_restart = restart && (r_state != ST_BOOT);

    // Hack jump condition: JLT/JEQ/JGT bits against the ALU flags
    assign w_jump = (r_instr[2] & ng) | (r_instr[1] & zr) | (r_instr[0] & ~zr & ~ng);

    // Next-state and output decode; restart preempts every other action
    always_comb begin
        w_next       = r_state;
        w_pc_reset   = 1'b0;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        w_rom_req    = 1'b0;
        w_exec_valid = 1'b0;
        w_halted     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_BOOT: begin
                // Wait one clock after reset release so the pulse is a full clean cycle
                if (r_armed) begin
                    w_pc_reset = 1'b1;
                    w_next     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_rom_req = 1'b1;
                if (w_restart) begin
                    w_next = ST_BOOT;
                end else if (rom.rom_ack) begin
                    w_capture = 1'b1;
                    w_next    = ST_EXEC;
                end else if (r_wait_cnt == WC_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = ST_HALT;
                end
            end
            ST_EXEC: begin
                w_exec_valid = 1'b1;
                if (w_restart) begin
                    w_next = ST_BOOT;
                end else if (exec_done) begin
                    w_retire = 1'b1;
                    if (r_instr[15] && w_jump) begin
                        w_pc_load = 1'b1;
                    end else begin
                        w_pc_inc = 1'b1;
                    end
                    w_next = halt_req ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                w_halted = 1'b1;
                if (w_restart) begin
                    w_next = ST_BOOT;
                end else if (!r_fetch_err && !halt_req) begin
                    w_next = ST_FETCH;
                end
            end
            default: w_next = ST_BOOT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_next;
        end
    end

    // Marks the first clock after reset release; stays set until the next reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Consecutive no-ack cycles in FETCH; zero whenever FETCH is (re)entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_FETCH) && !rom.rom_ack && !w_restart && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Instruction register, loaded on an accepted ROM handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr <= '0;
        end else if (w_capture) begin
            r_instr <= rom.rom_data;
        end
    end

    // Sticky fetch timeout flag, cleared only by reset or restart
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_err <= 1'b0;
        end else if (w_restart) begin
            r_fetch_err <= 1'b0;
        end else if (w_timeout) begin
            r_fetch_err <= 1'b1;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= '0;
        end else if (w_restart) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign pc_reset     = w_pc_reset;
    assign pc_load      = w_pc_load;
    assign pc_inc       = w_pc_inc;
    assign rom.rom_req  = w_rom_req;
    assign rom.rom_addr = w_rom_req ? pc_value[14:0] : 15'd0;
    assign instr        = r_instr;
    assign exec_valid   = w_exec_valid;
    assign halted       = w_halted;
    assign fetch_err    = r_fetch_err;
    assign retired      = r_retired;

endmodule

// File: tb/tb_hack_fetch_ctrl.sv
// Directed bench for hack_fetch_ctrl with a small PC register model and a
// fixed A-register jump target. Inputs change on the falling edge; outputs are
// checked on the falling edge (or 1 ns after an input change for the
// combinational EXEC decodes).
module tb_hack_fetch_ctrl;

    localparam logic [15:0] AREG = 16'h0100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] pc = 16'h1234;
    logic        pc_reset, pc_load, pc_inc;
    logic [15:0] instr;
    logic        exec_valid;
    logic        exec_done = 1'b0;
    logic        zr = 1'b0;
    logic        ng = 1'b0;
    logic        halt_req = 1'b0;
    logic        restart = 1'b0;
    logic        halted, fetch_err;
    logic [15:0] retired;

    int n_total = 0;
    int n_bad = 0;

    hack_fetch_ctrl_if rom_if ();

    hack_fetch_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pc_value   (pc),
        .pc_reset   (pc_reset),
        .pc_load    (pc_load),
        .pc_inc     (pc_inc),
        .rom        (rom_if.master),
        .instr      (instr),
        .exec_valid (exec_valid),
        .exec_done  (exec_done),
        .zr         (zr),
        .ng         (ng),
        .halt_req   (halt_req),
        .restart    (restart),
        .halted     (halted),
        .fetch_err  (fetch_err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Program counter register driven by the sequencer's controls
    always @(posedge clk) begin
        if (pc_reset)     pc <= 16'h0000;
        else if (pc_load) pc <= AREG;
        else if (pc_inc)  pc <= pc + 16'h0001;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called on a falling edge in FETCH: ack immediately, then complete EXEC
    task automatic fetch_exec(input string tag, input logic [15:0] data, input logic z, input logic n,
                              input logic exp_load, input logic exp_inc,
                              input logic [14:0] exp_addr, input logic [15:0] exp_ret);
        rom_if.rom_ack  = 1'b1;
        rom_if.rom_data = data;
        tick();
        rom_if.rom_ack = 1'b0;
        chk({tag, ".instr"}, instr, data);
        chk({tag, ".exec_valid"}, exec_valid, 1);
        exec_done = 1'b1;
        zr = z;
        ng = n;
        #1;
        chk({tag, ".pc_load"}, pc_load, exp_load);
        chk({tag, ".pc_inc"}, pc_inc, exp_inc);
        tick();
        exec_done = 1'b0;
        zr = 1'b0;
        ng = 1'b0;
        chk({tag, ".retired"}, retired, exp_ret);
        chk({tag, ".rom_req"}, rom_if.rom_req, 1);
        chk({tag, ".rom_addr"}, rom_if.rom_addr, exp_addr);
    endtask

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rom_if.rom_ack  = 1'b0;
        rom_if.rom_data = 16'h0000;
        #1 reset_n = 1'b0;
        tick();
        tick();
        chk("rst.pc_reset", pc_reset, 0);
        chk("rst.rom_req", rom_if.rom_req, 0);
        chk("rst.instr", instr, 16'h0000);
        chk("rst.retired", retired, 0);
        chk("rst.halted", halted, 0);
        chk("rst.fetch_err", fetch_err, 0);
        reset_n = 1'b1;

        // Reset release: one pc_reset cycle, then fetch from address 0
        tick();
        chk("boot.pc_reset", pc_reset, 1);
        chk("boot.rom_req", rom_if.rom_req, 0);
        tick();
        chk("boot.pulse_end", pc_reset, 0);
        chk("f0.rom_req", rom_if.rom_req, 1);
        chk("f0.rom_addr", rom_if.rom_addr, 0);
        chk("f0.retired", retired, 0);
        chk("f0.halted", halted, 0);
        rom_if.rom_data = 16'h0005;
        tick();
        chk("f0.wait2", rom_if.rom_req, 1);
        fetch_exec("i1", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0001, 16'd1);

        // Jump resolution cases (target 0x0100)
        fetch_exec("jmp",     16'hEA87, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0100, 16'd2);
        fetch_exec("jgt_zr",  16'hE301, 1'b1, 1'b0, 1'b0, 1'b1, 15'h0101, 16'd3);
        fetch_exec("jgt_pos", 16'hE301, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0100, 16'd4);
        fetch_exec("jlt_neg", 16'hE304, 1'b0, 1'b1, 1'b1, 1'b0, 15'h0100, 16'd5);
        fetch_exec("jlt_pos", 16'hE304, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0101, 16'd6);
        fetch_exec("jeq_zr",  16'hE302, 1'b1, 1'b0, 1'b1, 1'b0, 15'h0100, 16'd7);
        fetch_exec("a_low7",  16'h0007, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0101, 16'd8);

        // halt_req during EXEC: PC advances, then HALT until released
        rom_if.rom_ack  = 1'b1;
        rom_if.rom_data = 16'h0010;
        halt_req = 1'b1;
        tick();
        rom_if.rom_ack = 1'b0;
        exec_done = 1'b1;
        #1;
        chk("hlt.pc_inc", pc_inc, 1);
        tick();
        exec_done = 1'b0;
        chk("hlt.halted", halted, 1);
        chk("hlt.rom_req", rom_if.rom_req, 0);
        chk("hlt.retired", retired, 9);
        tick();
        chk("hlt.hold", halted, 1);
        halt_req = 1'b0;
        tick();
        chk("hlt.exit", halted, 0);
        chk("hlt.rom_addr", rom_if.rom_addr, 15'h0102);

        // Fetch timeout: four idle FETCH cycles, then sticky error in HALT
        tick();
        tick();
        tick();
        chk("to.err_before", fetch_err, 0);
        chk("to.req_before", rom_if.rom_req, 1);
        tick();
        chk("to.fetch_err", fetch_err, 1);
        chk("to.halted", halted, 1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        tick();
        chk("to.stuck", halted, 1);
        chk("to.no_req", rom_if.rom_req, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs.pc_reset", pc_reset, 1);
        chk("rs.fetch_err", fetch_err, 0);
        chk("rs.retired", retired, 0);
        chk("rs.halted", halted, 0);
        tick();
        chk("rs.rom_addr", rom_if.rom_addr, 0);
        fetch_exec("rs_i1", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0001, 16'd1);

        // Ack arriving on the timeout cycle is a normal capture
        tick();
        tick();
        tick();
        rom_if.rom_ack  = 1'b1;
        rom_if.rom_data = 16'hE307;
        tick();
        rom_if.rom_ack = 1'b0;
        chk("late.instr", instr, 16'hE307);
        chk("late.fetch_err", fetch_err, 0);
        chk("late.exec_valid", exec_valid, 1);

        // Restart coinciding with exec_done suppresses the PC update and retire
        exec_done = 1'b1;
        ng = 1'b1;
        restart = 1'b1;
        #1;
        chk("rx.pc_load", pc_load, 0);
        chk("rx.pc_inc", pc_inc, 0);
        tick();
        exec_done = 1'b0;
        ng = 1'b0;
        restart = 1'b0;
        chk("rx.pc_reset", pc_reset, 1);
        chk("rx.retired", retired, 0);
        chk("rx.exec_valid", exec_valid, 0);
        tick();
        chk("rx.rom_addr", rom_if.rom_addr, 0);

        // Asynchronous reset in the middle of EXEC
        rom_if.rom_ack  = 1'b1;
        rom_if.rom_data = 16'h8001;
        tick();
        rom_if.rom_ack = 1'b0;
        chk("ar.instr_pre", instr, 16'h8001);
        reset_n = 1'b0;
        #1;
        chk("ar.exec_valid", exec_valid, 0);
        chk("ar.instr", instr, 16'h0000);
        chk("ar.pc_reset", pc_reset, 0);
        tick();
        chk("ar.no_pulse", pc_reset, 0);
        reset_n = 1'b1;
        tick();
        chk("ar.pulse", pc_reset, 1);
        tick();
        chk("ar.rom_req", rom_if.rom_req, 1);
        chk("ar.pulse_end", pc_reset, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
